// File: rtl/bf16_arb_pkg.sv
// ----------------------------------------------------------------------------
// bf16_arb_pkg
// Shared definitions for the BF16 multiplier arbiter:
//   - arb_state_e : arbiter run/drain/halt state encoding
//   - BF16_QNAN, BF16_ONE : common BF16 bit patterns
//   - wrap_add()  : modular index helper for round-robin search
// ----------------------------------------------------------------------------
package bf16_arb_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_ONE  = 16'h3F80;

  // (base + inc) mod n for base < n and inc <= n; avoids a general divider.
  function automatic int wrap_add(int base, int inc, int n);
    return (base + inc >= n) ? (base + inc - n) : (base + inc);
  endfunction

endpackage

// File: rtl/bf16_arb_tag_fifo.sv
// ----------------------------------------------------------------------------
// bf16_arb_tag_fifo
// Small synchronous FIFO holding the requester ID of every operation that is
// in flight inside the shared multiplier. Show-ahead read: pop_data is the
// head entry whenever the FIFO is not empty.
// Push and pop in the same cycle are accepted at any occupancy, including
// full (the pop frees the slot the push fills).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write request and ID to store
//   pop             remove head entry (ignored when empty)
//   pop_data        head entry
//   full, empty     occupancy flags
//   count           number of stored entries (0..DEPTH)
// ----------------------------------------------------------------------------
module bf16_arb_tag_fifo #(
  parameter  int W     = 2,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving it unreset lets it map to plain flops or LUT RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bf16_mul_arbiter.sv
// ----------------------------------------------------------------------------
// bf16_mul_arbiter
// Shares one 3-stage BF16 multiplier between NUM_REQ requesters using
// round-robin arbitration. The winning operand pair is registered into the
// multiplier, the winner's ID travels through a tag FIFO alongside the
// operation, and each result is routed back (in issue order) to the
// requester that issued it. A drain input stops new grants and lets the
// pipeline empty; idle reports the fully halted state.
//
// Optional feature (macro BF16_ARB_PERF_EN): per-requester grant counters
// and a FIFO-full stall counter, clearable with perf_clr.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid[N]        per-requester operand valid
//   req_a/req_b[16N]    operands, slice i = [16i+15:16i]
//   req_ready[N]        one-hot grant (combinational, operand-independent)
//   drain               level request to stop accepting new work
//   idle                registered, high only in HALT
//   mul_a/mul_b         operands to multiplier
//   mul_in_valid        multiplier input strobe
//   mul_out_valid       multiplier output strobe
//   mul_result          multiplier result
//   rsp_valid[N]        one-hot registered result strobe
//   rsp_result          registered result
//   rsp_id              ID of current response
//   protocol_err        sticky: multiplier produced a result with no tag
//   perf_clr            (perf) synchronous counter clear
//   perf_grant_cnt      (perf) 32-bit grant counter per requester
//   perf_stall_cnt      (perf) RUN cycles stalled by a full tag FIFO
// ----------------------------------------------------------------------------
module bf16_mul_arbiter
  import bf16_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  drain,
  output logic                  idle,
  output logic [15:0]           mul_a,
  output logic [15:0]           mul_b,
  output logic                  mul_in_valid,
  input  logic                  mul_out_valid,
  input  logic [15:0]           mul_result,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [15:0]           rsp_result,
  output logic [ID_W-1:0]       rsp_id,
`ifdef BF16_ARB_PERF_EN
  input  logic                  perf_clr,
  output logic [32*NUM_REQ-1:0] perf_grant_cnt,
  output logic [31:0]           perf_stall_cnt,
`endif
  output logic                  protocol_err
);

  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  arb_state_e         state;
  arb_state_e         state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;
  logic               can_push;
  logic               handshake;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ID_W-1:0]    fifo_head;
  logic [NUM_REQ-1:0] rsp_onehot;

  // --------------------------------------------------------------------------
  // Tag FIFO: one entry per operation between issue and multiplier output.
  // --------------------------------------------------------------------------
  bf16_arb_tag_fifo #(
    .W     (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (handshake),
    .push_data (gnt_idx),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign fifo_pop = mul_out_valid & ~fifo_empty;

  // A full FIFO can still take a push in a cycle where a result pops, which
  // keeps one issue per cycle when TAG_DEPTH equals the round-trip depth.
  assign can_push = ~fifo_full | fifo_pop;

  // --------------------------------------------------------------------------
  // Round-robin search from rr_ptr upward, wrapping. Depends only on
  // req_valid, never on operand data.
  // --------------------------------------------------------------------------
  // NOTE: every variable written in always_comb is given a default first so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_valid[ID_W'(wrap_add(int'(rr_ptr), k, NUM_REQ))]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(wrap_add(int'(rr_ptr), k, NUM_REQ));
      end
    end
  end

  assign handshake = (state == ST_RUN) & can_push & gnt_found;

  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rsp_onehot            = '0;
    rsp_onehot[fifo_head] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Run/drain/halt sequencing.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_HALT:  if (!drain) state_nxt = ST_RUN;
      ST_RUN:   if (drain)  state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain)
          state_nxt = ST_RUN;
        else if (fifo_count == '0 && !mul_in_valid)
          state_nxt = ST_HALT;
      end
      default:  state_nxt = ST_HALT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Issue, response and status registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_HALT;
      idle         <= 1'b1;
      rr_ptr       <= '0;
      mul_in_valid <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      rsp_valid    <= '0;
      rsp_result   <= '0;
      rsp_id       <= '0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      // idle is registered from the next state so it lines up with HALT.
      idle         <= (state_nxt == ST_HALT);
      mul_in_valid <= handshake;
      if (handshake) begin
        mul_a  <= req_a[{gnt_idx, 4'b0000} +: 16];
        mul_b  <= req_b[{gnt_idx, 4'b0000} +: 16];
        rr_ptr <= ID_W'(wrap_add(int'(gnt_idx), 1, NUM_REQ));
      end
      rsp_valid <= fifo_pop ? rsp_onehot : '0;
      if (fifo_pop) begin
        rsp_result <= mul_result;
        rsp_id     <= fifo_head;
      end
      // A result with no outstanding tag cannot be routed; flag and drop it.
      if (mul_out_valid && fifo_empty) protocol_err <= 1'b1;
    end
  end

`ifdef BF16_ARB_PERF_EN
  // --------------------------------------------------------------------------
  // Performance counters (32-bit, wrapping). Clear has priority.
  // --------------------------------------------------------------------------
  logic stall;

  assign stall = (state == ST_RUN) & (|req_valid) & ~can_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else if (perf_clr) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (handshake && gnt_idx == ID_W'(i))
          perf_grant_cnt[32*i +: 32] <= perf_grant_cnt[32*i +: 32] + 32'd1;
      end
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bf16_mul_arbiter
// Directed bench for bf16_mul_arbiter with a 3-stage multiplier stub that
// can withhold its output strobe or have one forced. Covers reset, single
// issue latency, round-robin order, drain/idle, FIFO-full backpressure,
// protocol error and asynchronous mid-stream reset. Perf counters are
// checked when BF16_ARB_PERF_EN is defined.
// ----------------------------------------------------------------------------
module tb_bf16_mul_arbiter;
  import bf16_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic        drain;
  logic        idle;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_in_valid;
  logic        mul_out_valid;
  logic [15:0] mul_result;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_id;
  logic        protocol_err;
`ifdef BF16_ARB_PERF_EN
  logic         perf_clr;
  logic [127:0] perf_grant_cnt;
  logic [31:0]  perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bf16_mul_arbiter #(.NUM_REQ(4), .ID_W(2), .TAG_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_ready     (req_ready),
    .drain         (drain),
    .idle          (idle),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_in_valid  (mul_in_valid),
    .mul_out_valid (mul_out_valid),
    .mul_result    (mul_result),
    .rsp_valid     (rsp_valid),
    .rsp_result    (rsp_result),
    .rsp_id        (rsp_id),
`ifdef BF16_ARB_PERF_EN
    .perf_clr      (perf_clr),
    .perf_grant_cnt(perf_grant_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .protocol_err  (protocol_err)
  );

  // --------------------------------------------------------------------------
  // Multiplier stub: 3 register stages, normal-number BF16 multiply with
  // truncation. block suppresses its output strobe; force_ov injects one.
  // --------------------------------------------------------------------------
  logic [2:0]  pv;
  logic [15:0] pr [3];
  logic        block;
  logic        force_ov;
  logic [15:0] force_res;

  function automatic logic [15:0] bf16_mul_model(logic [15:0] a, logic [15:0] b);
    logic [15:0] prod;
    logic [7:0]  e;
    prod = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};
    e    = a[14:7] + b[14:7] - 8'd127;
    if (prod[15]) return {a[15] ^ b[15], e + 8'd1, prod[14:8]};
    else          return {a[15] ^ b[15], e, prod[13:7]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[1:0], mul_in_valid};
      pr[0] <= bf16_mul_model(mul_a, mul_b);
      pr[1] <= pr[0];
      pr[2] <= pr[1];
    end
  end

  assign mul_out_valid = (pv[2] & ~block) | force_ov;
  assign mul_result    = force_ov ? force_res : pr[2];

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; drain = 1'b0;
    block = 1'b0; force_ov = 1'b0; force_res = '0;
`ifdef BF16_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    #2;
    check("reset_idle",      128'(idle), 128'(1'b1));
    check("reset_ready",     128'(req_ready), 128'(4'b0000));
    check("reset_in_valid",  128'(mul_in_valid), 128'(1'b0));
    check("reset_rsp_valid", 128'(rsp_valid), 128'(4'b0000));
    check("reset_err",       128'(protocol_err), 128'(1'b0));
    check("reset_mul_a",     128'(mul_a), 128'(16'h0000));

    @(posedge clk); #1; rst = 1'b0;       // HALT cycle
    check("halt_idle", 128'(idle), 128'(1'b1));
    tick();                                // RUN
    check("run_idle", 128'(idle), 128'(1'b0));

    // ---- single request: req 1, 1.0 * 2.0 ---------------------------------
    set_ops(1, BF16_ONE, 16'h4000);
    req_valid = 4'b0010; #1;
    check("single_ready", 128'(req_ready), 128'(4'b0010));
    tick(); req_valid = '0;               // T+1
    check("single_in_valid", 128'(mul_in_valid), 128'(1'b1));
    check("single_mul_a",    128'(mul_a), 128'(16'h3F80));
    check("single_mul_b",    128'(mul_b), 128'(16'h4000));
    tick();                                // T+2
    check("single_in_idle",  128'(mul_in_valid), 128'(1'b0));
    check("single_a_hold",   128'(mul_a), 128'(16'h3F80));
    tick(); tick();                        // T+4
    check("single_no_rsp_t4", 128'(rsp_valid), 128'(4'b0000));
    tick();                                // T+5
    check("single_rsp_valid",  128'(rsp_valid), 128'(4'b0010));
    check("single_rsp_result", 128'(rsp_result), 128'(16'h4000));
    check("single_rsp_id",     128'(rsp_id), 128'(2'd1));
    tick();
    check("single_rsp_done", 128'(rsp_valid), 128'(4'b0000));

    // ---- round robin, all valid; rr_ptr starts at 2 ------------------------
    for (int i = 0; i < 4; i++) set_ops(i, 16'h3FC0, 16'h3FC0);
    for (int k = 0; k < 13; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0; #1;
      check($sformatf("rr_ready_%0d", k), 128'(req_ready),
            128'((k < 8) ? oh((2 + k) % 4) : 4'b0000));
      check($sformatf("rr_rsp_valid_%0d", k), 128'(rsp_valid),
            128'((k >= 5) ? oh((2 + k - 5) % 4) : 4'b0000));
      if (k >= 5) begin
        check($sformatf("rr_rsp_id_%0d", k), 128'(rsp_id), 128'((2 + k - 5) % 4));
        check($sformatf("rr_rsp_result_%0d", k), 128'(rsp_result), 128'(16'h4010));
      end
      tick();
    end

    // ---- drain with 3 ops in flight; rr_ptr back at 2 ----------------------
    for (int k = 0; k < 9; k++) begin
      req_valid = (k == 3) ? 4'h0 : 4'hF;
      drain     = (k >= 3);
      #1;
      check($sformatf("drain_ready_%0d", k), 128'(req_ready),
            128'((k < 3) ? oh((2 + k) % 4) : 4'b0000));
      check($sformatf("drain_rsp_valid_%0d", k), 128'(rsp_valid),
            128'((k >= 5 && k <= 7) ? oh((2 + k - 5) % 4) : 4'b0000));
      check($sformatf("drain_idle_%0d", k), 128'(idle), 128'(k == 8));
      tick();
    end
    drain = 1'b0; #1;                      // still HALT this cycle
    check("resume_halt_ready", 128'(req_ready), 128'(4'b0000));
    check("resume_halt_idle",  128'(idle), 128'(1'b1));
    tick();                                // RUN again, rr_ptr = 1
    check("resume_ready", 128'(req_ready), 128'(4'b0010));
    check("resume_idle",  128'(idle), 128'(1'b0));
    tick(); req_valid = '0;
    repeat (6) tick();

    // ---- withhold multiplier output until the tag FIFO fills ---------------
`ifdef BF16_ARB_PERF_EN
    perf_clr = 1'b1; tick(); perf_clr = 1'b0;
`endif
    block = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_valid = 4'hF; #1;
      check($sformatf("full_ready_%0d", k), 128'(req_ready),
            128'((k < 4) ? oh((2 + k) % 4) : 4'b0000));
      tick();
    end
    req_valid = '0;
`ifdef BF16_ARB_PERF_EN
    check("perf_stall_cnt", 128'(perf_stall_cnt), 128'(32'd2));
    check("perf_grant_cnt", perf_grant_cnt, {32'd1, 32'd1, 32'd1, 32'd1});
`endif
    repeat (3) tick();
    block = 1'b0;

    // ---- pop the four stored tags with forced results ----------------------
    for (int k = 0; k < 5; k++) begin
      force_ov  = (k < 4);
      force_res = 16'h1000 + 16'(k);
      #1;
      if (k >= 1) begin
        check($sformatf("forced_rsp_valid_%0d", k), 128'(rsp_valid), 128'(oh((2 + k - 1) % 4)));
        check($sformatf("forced_rsp_id_%0d", k), 128'(rsp_id), 128'((2 + k - 1) % 4));
        check($sformatf("forced_rsp_result_%0d", k), 128'(rsp_result), 128'(16'h1000 + 16'(k - 1)));
      end
      check($sformatf("forced_no_err_%0d", k), 128'(protocol_err), 128'(1'b0));
      tick();
    end

    // ---- result with empty FIFO -------------------------------------------
    force_ov = 1'b1; force_res = BF16_QNAN;
    tick(); force_ov = 1'b0;
    check("err_set",        128'(protocol_err), 128'(1'b1));
    check("err_no_rsp",     128'(rsp_valid), 128'(4'b0000));
    check("err_result_hold", 128'(rsp_result), 128'(16'h1003));
    tick(); tick();
    check("err_sticky", 128'(protocol_err), 128'(1'b1));

    // ---- asynchronous reset mid-stream -------------------------------------
    set_ops(0, BF16_ONE, 16'h4040);
    req_valid = 4'hF;
    tick(); tick();
    check("pre_rst_in_valid", 128'(mul_in_valid), 128'(1'b1));
    #2; rst = 1'b1; #1;
    check("async_rst_in_valid", 128'(mul_in_valid), 128'(1'b0));
    check("async_rst_ready",    128'(req_ready), 128'(4'b0000));
    check("async_rst_err",      128'(protocol_err), 128'(1'b0));
    check("async_rst_idle",     128'(idle), 128'(1'b1));
    check("async_rst_rsp",      128'(rsp_valid), 128'(4'b0000));
    check("async_rst_mul_a",    128'(mul_a), 128'(16'h0000));
    @(posedge clk); #1; rst = 1'b0;
    check("post_rst_halt_ready", 128'(req_ready), 128'(4'b0000));
    tick();                                // RUN, rr_ptr = 0
    check("post_rst_ready", 128'(req_ready), 128'(4'b0001));
    check("post_rst_idle",  128'(idle), 128'(1'b0));
    tick(); req_valid = '0;
    check("post_rst_mul_b", 128'(mul_b), 128'(16'h4040));
    repeat (4) tick();
    check("post_rst_rsp_valid",  128'(rsp_valid), 128'(4'b0001));
    check("post_rst_rsp_result", 128'(rsp_result), 128'(16'h4040));
    check("post_rst_rsp_id",     128'(rsp_id), 128'(2'd0));
    check("post_rst_no_err",     128'(protocol_err), 128'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bf16_mul_arbiter.md
Name: bf16_mul_arbiter

Overview:
- Shares one 3-stage bf16_multiplier between NUM_REQ requesters using round-robin arbitration.
- Registers the winning operand pair into the multiplier and carries the requester ID alongside each in-flight operation.
- Routes each multiplier result back to the requester that issued it.
- Sits between MAC-array lane controllers and a single multiplier instance. Provides drain/idle sequencing for reconfiguration.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- TAG_DEPTH, 4, in-flight tag FIFO depth; must be ≥ multiplier latency + 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_a  in  16*NUM_REQ  BF16 operand A; slice i = [16i+15:16i]
- req_b  in  16*NUM_REQ  BF16 operand B; same slicing as req_a
- req_ready  out  NUM_REQ  one-hot grant; combinational
- drain  in  1  level request to stop accepting new work
- idle  out  1  registered; high when halted with nothing in flight
- mul_a  out  16  to multiplier a
- mul_b  out  16  to multiplier b
- mul_in_valid  out  1  to multiplier in_valid
- mul_out_valid  in  1  from multiplier out_valid
- mul_result  in  16  from multiplier result
- rsp_valid  out  NUM_REQ  one-hot result strobe, registered
- rsp_result  out  16  result data, registered
- rsp_id  out  ID_W  ID of current response
- protocol_err  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0, except idle=1. Reset also sets state=HALT, rr_ptr=0, tag FIFO empty, protocol_err=0.
- Reset is asynchronous and may occur mid-operation. In-flight results are discarded, but a multiplier out_valid after reset will assert protocol_err. The integrator must reset the multiplier together with this block.
- FSM states: RUN, DRAIN, HALT.
  - HALT→RUN: when drain=0.
  - RUN→DRAIN: when drain=1.
  - DRAIN→HALT: when the tag FIFO is empty and no mul_in_valid is pending.
  - DRAIN→RUN: when drain deasserts before HALT is reached.
- Grants only in RUN and only when the tag FIFO is not full.
- Arbitration:
  - Grant the first i with req_valid[i], searching from rr_ptr upward and wrapping.
  - On grant i, set rr_ptr to (i+1) mod NUM_REQ. rr_ptr holds when there is no grant.
  - A handshake is req_valid[i] & req_ready[i]. req_ready must not depend on req_a or req_b.
- Issue: cycle T handshake gives, at T+1, mul_in_valid=1, mul_a/mul_b = granted operands, and the ID pushed to the tag FIFO. mul_in_valid is 0 in cycles without a handshake; mul_a/mul_b hold their values.
- Return path:
  - On mul_out_valid, pop the tag FIFO.
  - Next cycle: rsp_valid[tag]=1, rsp_result=mul_result, rsp_id=tag.
  - End-to-end latency with a 3-cycle multiplier: handshake T → rsp T+5. Responses are in issue order.
  - No response backpressure; requesters must always accept.
- Throughput: one issue per cycle. Simultaneous push and pop in the same cycle is legal at any occupancy, including full (pop then push).
- Errors: mul_out_valid while the FIFO is empty sets protocol_err (sticky until rst), and no response is generated.
- idle=1 only in HALT.

Optional Feature:
- Macro: BF16_ARB_PERF_EN.
- When defined, adds outputs:
  - perf_grant_cnt (32*NUM_REQ): per-requester grants.
  - perf_stall_cnt (32): cycles in RUN with any req_valid but no grant, due to a full FIFO.
  - Counters are 32-bit wrapping, cleared by rst, and also cleared by a new input perf_clr (synchronous, priority over increment).
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package bf16_arb_pkg holds:
  - arbiter state encoding (RUN/DRAIN/HALT);
  - BF16 constants: qNaN 16'h7FC0, +1.0 16'h3F80.
- One natural sub-module: bf16_arb_tag_fifo (ID_W wide, TAG_DEPTH deep; push, pop, full, empty, count).
- The round-robin priority logic stays inline.

Test Plan:
- Single request: requester 1 sends 0x3F80*0x4000 at T → rsp_valid=4'b0010, rsp_result=0x4000, rsp_id=1 at T+5.
- All four requesters valid continuously → grants in order 0,1,2,3,0,…, one per cycle. Each requester receives 0x3FC0*0x3FC0=0x4010 in grant order.
- drain=1 with 3 ops in flight → no new grants; idle=1 one cycle after the last rsp_valid. Then drain=0 → grants resume from rr_ptr.
- Multiplier stubbed to withhold out_valid so the FIFO fills → req_ready=0. With BF16_ARB_PERF_EN, perf_stall_cnt increments each such cycle.
- mul_out_valid forced with FIFO empty → protocol_err=1, no rsp_valid. Stays 1 until rst.
- rst asserted mid-stream → outputs 0 immediately (async), idle=1. After release with drain=0, RUN within 1 cycle and the first grant goes to requester 0.
